exec_unit: RTL and testbench

Execute stage of the 16-bit microprocessor, directly downstream of the instruction decoder. It consumes the decoded fields of the current instruction and holds the 8×16 register file, ALU, Z/N/C flags and a 16-step sequential multiplier. It drives `branch` and `nia` back to the program counter to redirect or stall fetch.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/regfile.sv | 27 ++
 rtl/exec_unit.sv | 116 +++++++++++
 tb/tb_exec_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU: widths, opcodes, and execute-stage FSM encoding.
package cpu_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int OPFN_W    = 5;
  localparam int ADDR_W    = 8;

  localparam logic [OPFN_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OPFN_W-1:0] OP_ADD  = 5'h01;
  localparam logic [OPFN_W-1:0] OP_SUB  = 5'h02;
  localparam logic [OPFN_W-1:0] OP_AND  = 5'h03;
  localparam logic [OPFN_W-1:0] OP_OR   = 5'h04;
  localparam logic [OPFN_W-1:0] OP_XOR  = 5'h05;
  localparam logic [OPFN_W-1:0] OP_ADDI = 5'h06;
  localparam logic [OPFN_W-1:0] OP_LI   = 5'h07;
  localparam logic [OPFN_W-1:0] OP_LUI  = 5'h08;
  localparam logic [OPFN_W-1:0] OP_SLL  = 5'h09;
  localparam logic [OPFN_W-1:0] OP_MUL  = 5'h0A;
  localparam logic [OPFN_W-1:0] OP_BEQ  = 5'h0C;
  localparam logic [OPFN_W-1:0] OP_BNE  = 5'h0D;
  localparam logic [OPFN_W-1:0] OP_JMP  = 5'h0E;
  localparam logic [OPFN_W-1:0] OP_BZ   = 5'h0F;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/regfile.sv
// 8x16 register file: two read ports plus a debug port, one synchronous write, R0 hardwired to zero.
module regfile
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [DATA_W-1:0]    wd,
  output logic [DATA_W-1:0]    rd_a,
  output logic [DATA_W-1:0]    rd_b,
  output logic [DATA_W-1:0]    dbg_data
);
  logic [7:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) mem <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
  end

  assign rd_a     = (ra == '0)      ? '0 : mem[ra];
  assign rd_b     = (rb == '0)      ? '0 : mem[rb];
  assign dbg_data = (dbg_sel == '0) ? '0 : mem[dbg_sel];
endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, Z/N/C flags, branch decision and a shift-add multiply sequencer over the register file.
module exec_unit
  import cpu_pkg::*;
#(
  parameter int MUL_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra_i,
  input  logic [REG_IDX_W-1:0] rb_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic [6:0]           immj,
  input  logic [ADDR_W-1:0]    imm,
  input  logic [OPFN_W-1:0]    opfn,
  output logic                 branch,
  output logic                 nia,
  output logic [2:0]           flags,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data
);
  localparam int CNT_W = $clog2(MUL_STEPS);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_W-1:0]      mcand, mplier, acc, step_acc;
  logic [REG_IDX_W-1:0]   dest;
  logic [DATA_W-1:0]      a, b, res, wd;
  logic [REG_IDX_W-1:0]   rb_sel, wa;
  logic                   c, alu_wr, alu_fl, we, fl_we;
  logic [2:0]             flags_n;
  logic [DATA_W:0]        sum;

  // LUI needs the old low byte of rd, so port B is borrowed for it
  assign rb_sel = (opfn == OP_LUI) ? rd_i : rb_i;

  regfile u_rf (
    .clk(clk), .rst(rst), .ra(ra_i), .rb(rb_sel), .dbg_sel(dbg_sel),
    .we(we), .wa(wa), .wd(wd), .rd_a(a), .rd_b(b), .dbg_data(dbg_data)
  );

  always_comb begin
    res = '0; c = 1'b0; alu_wr = 1'b0; alu_fl = 1'b0; sum = '0;
    case (opfn)
      OP_ADD:  begin sum = {1'b0, a} + {1'b0, b}; res = sum[DATA_W-1:0]; c = sum[DATA_W];
                     alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_SUB:  begin res = a - b; c = a < b; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_AND:  begin res = a & b; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_OR:   begin res = a | b; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_XOR:  begin res = a ^ b; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_ADDI: begin sum = {1'b0, a} + {1'b0, {{(DATA_W-7){immj[6]}}, immj}};
                     res = sum[DATA_W-1:0]; c = sum[DATA_W]; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_LI:   begin res = {8'h00, imm}; alu_wr = 1'b1; end
      OP_LUI:  begin res = {imm, b[7:0]}; alu_wr = 1'b1; end
      OP_SLL:  begin res = a << b[3:0]; alu_wr = 1'b1; alu_fl = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    branch = 1'b0;
    if (!rst && state == ST_IDLE) begin
      case (opfn)
        OP_BEQ:  branch = (a == b);
        OP_BNE:  branch = (a != b);
        OP_JMP:  branch = 1'b1;
        OP_BZ:   branch = flags[2];
        default: branch = 1'b0;
      endcase
    end
  end

  assign step_acc = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_n = state; nia = 1'b0; we = 1'b0; fl_we = 1'b0;
    wa = rd_i; wd = res; flags_n = {res == '0, res[DATA_W-1], c};
    case (state)
      ST_IDLE: begin
        if (opfn == OP_MUL) begin
          nia = 1'b1; state_n = ST_BUSY;
        end else begin
          we = alu_wr; fl_we = alu_fl;
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_W'(MUL_STEPS-1)) begin
          we = 1'b1; fl_we = 1'b1; wa = dest; wd = step_acc;
          flags_n = {step_acc == '0, step_acc[DATA_W-1], 1'b0};
          state_n = ST_IDLE;
        end else begin
          nia = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin nia = 1'b0; we = 1'b0; fl_we = 1'b0; end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; flags <= '0;
    end else begin
      if (fl_we) flags <= flags_n;
      if (state == ST_IDLE && opfn == OP_MUL) begin
        mcand <= a; mplier <= b; dest <= rd_i; acc <= '0; cnt <= '0;
      end else if (state == ST_BUSY) begin
        acc <= step_acc; mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: per-cycle reference model comparison plus hand-computed literal checks.
module tb_exec_unit;
  import cpu_pkg::*;

  logic        clk = 0, rst = 1;
  logic [2:0]  ra_i = 0, rb_i = 0, rd_i = 0, dbg_sel = 0;
  logic [6:0]  immj = 0;
  logic [7:0]  imm = 0;
  logic [4:0]  opfn = 0;
  logic        branch, nia;
  logic [2:0]  flags;
  logic [15:0] dbg_data;
  int checks = 0, failures = 0;

  exec_unit #(.MUL_STEPS(16)) dut (
    .clk(clk), .rst(rst), .ra_i(ra_i), .rb_i(rb_i), .rd_i(rd_i), .immj(immj),
    .imm(imm), .opfn(opfn), .branch(branch), .nia(nia), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers, flags and a countdown of remaining multiply cycles.
  logic [15:0] cr[8], nr[8];
  logic [2:0]  cf, nf, cd, nd;
  logic [15:0] cp, np;
  int          cb, nb;
  bit          m_en = 0;

  initial begin : model
    logic [15:0] a, b, res;
    logic [16:0] s;
    logic [31:0] prod;
    logic        c, wr, fl, eb, en_n;
    forever begin
      @(negedge clk);
      nr = cr; nf = cf; nb = cb; np = cp; nd = cd; en_n = m_en;
      a = (ra_i == 0) ? 16'h0 : cr[ra_i];
      b = (rb_i == 0) ? 16'h0 : cr[rb_i];
      if (m_en) begin
        eb = 0;
        if (!rst && cb == 0)
          case (opfn)
            OP_BEQ: eb = (a == b);
            OP_BNE: eb = (a != b);
            OP_JMP: eb = 1;
            OP_BZ:  eb = cf[2];
            default: eb = 0;
          endcase
        chk("branch", branch, eb);
        chk("nia", nia, rst ? 1'b0 : (cb > 0 ? (cb > 1) : (opfn == OP_MUL)));
        chk("flags", flags, cf);
        chk("dbg_data", dbg_data, (dbg_sel == 0) ? 16'h0 : cr[dbg_sel]);
      end
      if (rst) begin
        for (int i = 0; i < 8; i++) nr[i] = 0;
        nf = 0; nb = 0; en_n = 1;
      end else if (m_en && cb > 0) begin
        nb = cb - 1;
        if (cb == 1) begin
          if (cd != 0) nr[cd] = cp;
          nf = {cp == 0, cp[15], 1'b0};
        end
      end else if (m_en) begin
        res = 0; c = 0; wr = 1; fl = 1;
        case (opfn)
          OP_ADD:  begin s = a + b; res = s[15:0]; c = s[16]; end
          OP_SUB:  begin res = a - b; c = (a < b); end
          OP_AND:  res = a & b;
          OP_OR:   res = a | b;
          OP_XOR:  res = a ^ b;
          OP_ADDI: begin s = a + {{9{immj[6]}}, immj}; res = s[15:0]; c = s[16]; end
          OP_LI:   begin res = {8'h00, imm}; fl = 0; end
          OP_LUI:  begin res = {imm, cr[rd_i][7:0]}; fl = 0; end
          OP_SLL:  res = a << b[3:0];
          OP_MUL:  begin prod = a * b; np = prod[15:0]; nd = rd_i; nb = 16; wr = 0; fl = 0; end
          default: begin wr = 0; fl = 0; end
        endcase
        if (wr && rd_i != 0) nr[rd_i] = res;
        if (fl) nf = {res == 0, res[15], c};
      end
      @(posedge clk);
      cr = nr; cf = nf; cb = nb; cp = np; cd = nd; m_en = en_n;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] d, input logic [2:0] x,
                       input logic [2:0] y, input logic [7:0] i8, input logic [6:0] i7);
    opfn = op; rd_i = d; ra_i = x; rb_i = y; imm = i8; immj = i7;
  endtask

  task automatic ex(input logic [4:0] op, input logic [2:0] d, input logic [2:0] x,
                    input logic [2:0] y, input logic [7:0] i8, input logic [6:0] i7);
    drive(op, d, x, y, i8, i7); tick();
  endtask

  task automatic peek(input string name, input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel; #1; chk(name, dbg_data, exp);
  endtask

  initial begin
    int nia_cnt;
    rst = 1; tick(); tick(); rst = 0;
    peek("reset_r3", 3, 16'h0); chk("reset_flags", flags, 3'b000);

    ex(OP_LI, 1, 0, 0, 8'h05, 0); ex(OP_LI, 2, 0, 0, 8'h03, 0);
    ex(OP_ADD, 3, 1, 2, 0, 0);
    peek("add_r3", 3, 16'h0008); chk("add_flags", flags, 3'b000);

    ex(OP_LI, 1, 0, 0, 8'hFF, 0); ex(OP_LUI, 1, 0, 0, 8'hFF, 0);
    peek("lui_r1", 1, 16'hFFFF);
    ex(OP_ADDI, 2, 1, 0, 0, 7'h01);
    peek("addi_r2", 2, 16'h0000); chk("addi_flags", flags, 3'b101);
    drive(OP_BZ, 0, 0, 0, 8'h40, 0); #1; chk("bz_taken", branch, 1'b1); tick();

    ex(OP_LI, 2, 0, 0, 8'h02, 0); ex(OP_LI, 1, 0, 0, 8'h05, 0);
    ex(OP_SUB, 3, 2, 1, 0, 0);
    peek("sub_r3", 3, 16'hFFFD); chk("sub_flags", flags, 3'b011);
    drive(OP_BZ, 0, 0, 0, 8'h40, 0); #1; chk("bz_not_taken", branch, 1'b0); tick();
    ex(OP_SLL, 5, 3, 2, 0, 0);
    peek("sll_r5", 5, 16'hFFF4); chk("sll_flags", flags, 3'b010);
    ex(OP_XOR, 6, 5, 3, 0, 0); peek("xor_r6", 6, 16'h0009);
    ex(OP_OR, 7, 1, 2, 0, 0); ex(OP_AND, 7, 7, 1, 0, 0); peek("and_r7", 7, 16'h0005);
    ex(OP_ADDI, 5, 1, 0, 0, 7'h7E);
    peek("addi_neg_r5", 5, 16'h0003); chk("addi_neg_flags", flags, 3'b001);

    ex(OP_LI, 1, 0, 0, 8'h23, 0); ex(OP_LUI, 1, 0, 0, 8'h01, 0); ex(OP_LI, 2, 0, 0, 8'h11, 0);
    drive(OP_MUL, 4, 1, 2, 0, 0);
    nia_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      #1; if (nia) nia_cnt++;
      tick();
      if (i < 16) begin
        if (i % 2 == 0) drive(OP_LI, 4, 0, 0, 8'h77, 0);
        else            drive(OP_JMP, 0, 0, 0, 8'h10, 0);
      end else drive(OP_NOP, 0, 0, 0, 0, 0);
    end
    chk("mul_nia_cycles", nia_cnt, 16);
    peek("mul_r4", 4, 16'h1353); chk("mul_flags", flags, 3'b000);

    ex(OP_LI, 1, 0, 0, 8'h07, 0); ex(OP_LI, 2, 0, 0, 8'h07, 0);
    drive(OP_BEQ, 0, 1, 2, 8'h20, 0); #1; chk("beq_taken", branch, 1'b1);
    drive(OP_BNE, 0, 1, 2, 8'h20, 0); #1; chk("bne_not_taken", branch, 1'b0);
    tick();

    ex(OP_LI, 0, 0, 0, 8'h55, 0); peek("r0_zero", 0, 16'h0000);

    ex(OP_MUL, 0, 1, 2, 0, 0);
    drive(OP_NOP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick();
    peek("mul_r0_zero", 0, 16'h0000); chk("mul_r0_flags", flags, 3'b000);

    ex(OP_LI, 4, 0, 0, 8'h99, 0);
    ex(OP_MUL, 4, 1, 2, 0, 0);
    drive(OP_NOP, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick();
    rst = 1; #1; chk("rst_nia", nia, 1'b0); chk("rst_branch", branch, 1'b0);
    tick(); rst = 0;
    peek("rst_r4", 4, 16'h0000); chk("rst_idle_nia", nia, 1'b0);
    ex(OP_LI, 3, 0, 0, 8'h42, 0); peek("post_rst_li", 3, 16'h0042);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
